// File: rtl/fib_pkg.sv
// Shared FIB definitions: entry field layout, multicast bit and FSM state encodings.
package fib_pkg;

    localparam int MAC_W       = 48;
    localparam int FIB_MACADDR = 0;       // lsb of the mac field in an entry
    localparam int FIB_PORT    = MAC_W;   // lsb of the port field
    localparam int MCAST_BIT   = 40;      // I/G bit of the first octet on the wire

    // The age field sits directly above the port field, whose width is a parameter.
    function automatic int fib_age_lsb(input int port_sz);
        return FIB_PORT + port_sz;
    endfunction

    typedef enum logic [6:0] {
        ST_INIT   = 7'b000_0001,
        ST_IDLE   = 7'b000_0010,
        ST_DA_RES = 7'b000_0100,
        ST_SA_RD  = 7'b000_1000,
        ST_SA_RES = 7'b001_0000,
        ST_AGE_RD = 7'b010_0000,
        ST_AGE_WR = 7'b100_0000
    } fib_state_t;

endpackage

// File: rtl/basic_hashfunc.sv
// FIB index hash: XOR-fold of the key into OUT_WIDTH bits.
// Purely combinational, zero latency, no flow control.
module basic_hashfunc #(
    parameter int IN_WIDTH  = 48,
    parameter int OUT_WIDTH = 8
) (
    input  logic [IN_WIDTH-1:0]  hf_data,
    output logic [OUT_WIDTH-1:0] hf_out
);

    localparam int CHUNKS = (IN_WIDTH + OUT_WIDTH - 1) / OUT_WIDTH;

    logic [CHUNKS*OUT_WIDTH-1:0] padded;

    assign padded = (CHUNKS*OUT_WIDTH)'(hf_data);

    always_comb begin
        hf_out = '0;
        for (int i = 0; i < CHUNKS; i++) begin
            hf_out = hf_out ^ padded[i*OUT_WIDTH +: OUT_WIDTH];
        end
    end

endmodule

// File: rtl/fib_age_tick.sv
// Aging interval timer: one-cycle tick every AGE_INTERVAL enabled cycles.
// Tick is combinational from the count; counter freezes while en is low.
module fib_age_tick #(
    parameter int AGE_INTERVAL = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic tick
);

    localparam int CW = (AGE_INTERVAL > 2) ? $clog2(AGE_INTERVAL) : 1;
    localparam logic [CW-1:0] LAST = CW'(AGE_INTERVAL - 1);

    logic [CW-1:0] cnt;

    assign tick = en && (cnt == LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/fib_lookup_ctl.sv
// Bridge FIB controller: DA lookup -> port mask, SA learn, background aging; FIB_STATS_EN adds hit/miss/filter counters.
// Latency: unicast descriptor consumed 4 cycles after acceptance (multicast 3), plus 2 per interleaved aging step.
// Backpressure: mask held on lout_* until lout_drdy; lpp descriptor held until the one-cycle lpp_drdy pulse.
module fib_lookup_ctl
    import fib_pkg::*;
#(
    parameter int NUM_PORTS    = 4,
    parameter int PORT_SZ      = 2,
    parameter int FIB_ASZ      = 8,
    parameter int AGE_SZ       = 4,
    parameter int MAX_AGE      = 15,
    parameter int AGE_INTERVAL = 1024
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [47:0]                   lpp_macda,
    input  logic [47:0]                   lpp_macsa,
    input  logic [PORT_SZ-1:0]            lpp_srcport,
    input  logic                          lpp_srdy,
    output logic                          lpp_drdy,
    output logic                          ft_rd_n,
    output logic                          ft_wr_n,
    output logic [FIB_ASZ-1:0]            ft_addr,
    output logic [48+PORT_SZ+AGE_SZ-1:0]  ft_wdata,
    input  logic [48+PORT_SZ+AGE_SZ-1:0]  ft_rdata,
    output logic [NUM_PORTS-1:0]          lout_data,
    output logic                          lout_srdy,
    input  logic                          lout_drdy
`ifdef FIB_STATS_EN
    ,
    output logic [15:0]                   stat_hit,
    output logic [15:0]                   stat_miss,
    output logic [15:0]                   stat_filter
`endif
);

    localparam int AGE_LSB = fib_age_lsb(PORT_SZ);

    fib_state_t           state;
    logic [FIB_ASZ-1:0]   init_cnt;
    logic [FIB_ASZ-1:0]   age_ptr;
    logic                 age_pend;
    logic                 mc_offer;
    logic                 da_held;
    logic [NUM_PORTS-1:0] da_mask_q;
    logic                 tick;

    logic [MAC_W-1:0]     rd_mac;
    logic [PORT_SZ-1:0]   rd_port;
    logic [AGE_SZ-1:0]    rd_age;
    logic [MAC_W-1:0]     hash_key;
    logic [MAC_W-1:0]     lk_mac;
    logic [FIB_ASZ-1:0]   hash_idx;
    logic                 hit;
    logic                 same_port;
    logic [NUM_PORTS-1:0] flood;
    logic [NUM_PORTS-1:0] da_mask;
    logic                 mcast;
    logic                 take_age;

    assign rd_mac    = ft_rdata[FIB_MACADDR +: MAC_W];
    assign rd_port   = ft_rdata[FIB_PORT +: PORT_SZ];
    assign rd_age    = ft_rdata[AGE_LSB +: AGE_SZ];

    assign hash_key  = (state == ST_SA_RD || state == ST_SA_RES) ? lpp_macsa : lpp_macda;
    assign lk_mac    = (state == ST_SA_RES) ? lpp_macsa : lpp_macda;
    assign hit       = (rd_age != '0) && (rd_mac == lk_mac);
    assign same_port = (rd_port == lpp_srcport);
    assign flood     = ~(NUM_PORTS'(1) << lpp_srcport);
    assign da_mask   = !hit ? flood : (same_port ? '0 : NUM_PORTS'(1) << rd_port);
    assign mcast     = lpp_macda[MCAST_BIT];
    // A multicast mask already on lout_* is not retracted for aging.
    assign take_age  = age_pend && !mc_offer;

    basic_hashfunc #(
        .IN_WIDTH  (MAC_W),
        .OUT_WIDTH (FIB_ASZ)
    ) u_hash (
        .hf_data (hash_key),
        .hf_out  (hash_idx)
    );

    fib_age_tick #(
        .AGE_INTERVAL (AGE_INTERVAL)
    ) u_age_tick (
        .clk   (clk),
        .reset (reset),
        .en    (state != ST_INIT),
        .tick  (tick)
    );

    always_comb begin
        lpp_drdy  = 1'b0;
        ft_rd_n   = 1'b1;
        ft_wr_n   = 1'b1;
        ft_addr   = '0;
        ft_wdata  = '0;
        lout_srdy = 1'b0;
        lout_data = '0;
        if (!reset) begin
            case (state)
                ST_INIT: begin
                    ft_wr_n = 1'b0;
                    ft_addr = init_cnt;
                end
                ST_IDLE: begin
                    if (!take_age && lpp_srdy) begin
                        if (mcast) begin
                            lout_srdy = 1'b1;
                            lout_data = flood;
                        end else begin
                            ft_rd_n = 1'b0;
                            ft_addr = hash_idx;
                        end
                    end
                end
                ST_DA_RES: begin
                    lout_srdy = 1'b1;
                    lout_data = da_held ? da_mask_q : da_mask;
                end
                ST_SA_RD: begin
                    ft_rd_n = 1'b0;
                    ft_addr = hash_idx;
                end
                ST_SA_RES: begin
                    lpp_drdy = 1'b1;
                    ft_addr  = hash_idx;
                    ft_wdata = {AGE_SZ'(MAX_AGE), lpp_srcport, lpp_macsa};
                    if (!(hit && same_port && rd_age == AGE_SZ'(MAX_AGE))) begin
                        ft_wr_n = 1'b0;
                    end
                end
                ST_AGE_RD: begin
                    ft_rd_n = 1'b0;
                    ft_addr = age_ptr;
                end
                ST_AGE_WR: begin
                    ft_addr  = age_ptr;
                    ft_wdata = {rd_age - AGE_SZ'(1), rd_port, rd_mac};
                    if (rd_age != '0) begin
                        ft_wr_n = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_INIT;
            init_cnt  <= '0;
            age_ptr   <= '0;
            age_pend  <= 1'b0;
            mc_offer  <= 1'b0;
            da_held   <= 1'b0;
            da_mask_q <= '0;
        end else begin
            if (state == ST_AGE_WR) begin
                age_pend <= 1'b0;
            end else if (tick) begin
                age_pend <= 1'b1;
            end
            case (state)
                ST_INIT: begin
                    init_cnt <= init_cnt + FIB_ASZ'(1);
                    if (init_cnt == '1) begin
                        state <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    mc_offer <= 1'b0;
                    if (take_age) begin
                        state <= ST_AGE_RD;
                    end else if (lpp_srdy) begin
                        if (mcast) begin
                            if (lout_drdy) begin
                                state <= ST_SA_RD;
                            end else begin
                                mc_offer <= 1'b1;
                            end
                        end else begin
                            state <= ST_DA_RES;
                        end
                    end
                end
                ST_DA_RES: begin
                    // RAM read data is only valid for one cycle; keep the mask while stalled.
                    if (lout_drdy) begin
                        da_held <= 1'b0;
                        state   <= ST_SA_RD;
                    end else if (!da_held) begin
                        da_held   <= 1'b1;
                        da_mask_q <= da_mask;
                    end
                end
                ST_SA_RD:  state <= ST_SA_RES;
                ST_SA_RES: state <= ST_IDLE;
                ST_AGE_RD: state <= ST_AGE_WR;
                ST_AGE_WR: begin
                    age_ptr <= age_ptr + FIB_ASZ'(1);
                    state   <= ST_IDLE;
                end
                default:   state <= ST_INIT;
            endcase
        end
    end

`ifdef FIB_STATS_EN
    logic hit_q;
    logic filt_q;
    logic eff_hit;
    logic eff_filt;

    assign eff_hit  = da_held ? hit_q  : hit;
    assign eff_filt = da_held ? filt_q : (hit && same_port);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hit_q       <= 1'b0;
            filt_q      <= 1'b0;
            stat_hit    <= '0;
            stat_miss   <= '0;
            stat_filter <= '0;
        end else if (state == ST_DA_RES) begin
            if (!da_held) begin
                hit_q  <= hit;
                filt_q <= hit && same_port;
            end
            if (lout_drdy) begin
                if (!eff_hit) begin
                    if (stat_miss != '1) stat_miss <= stat_miss + 16'd1;
                end else if (eff_filt) begin
                    if (stat_filter != '1) stat_filter <= stat_filter + 16'd1;
                end else begin
                    if (stat_hit != '1) stat_hit <= stat_hit + 16'd1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_fib_lookup_ctl.sv
// Self-checking bench for fib_lookup_ctl: directed scenarios plus randomized traffic against a MAC-table model.
// The bench also plays the single-port FIB RAM.
module tb_fib_lookup_ctl;

    logic        clk;
    logic        reset;
    logic [47:0] lpp_macda;
    logic [47:0] lpp_macsa;
    logic [1:0]  lpp_srcport;
    logic        lpp_srdy;
    logic        lpp_drdy;
    logic        ft_rd_n;
    logic        ft_wr_n;
    logic [3:0]  ft_addr;
    logic [53:0] ft_wdata;
    logic [53:0] ft_rdata;
    logic [3:0]  lout_data;
    logic        lout_srdy;
    logic        lout_drdy;

    int errs;
    int checks;

    fib_lookup_ctl #(
        .NUM_PORTS    (4),
        .PORT_SZ      (2),
        .FIB_ASZ      (4),
        .AGE_SZ       (4),
        .MAX_AGE      (3),
        .AGE_INTERVAL (64)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .lpp_macda   (lpp_macda),
        .lpp_macsa   (lpp_macsa),
        .lpp_srcport (lpp_srcport),
        .lpp_srdy    (lpp_srdy),
        .lpp_drdy    (lpp_drdy),
        .ft_rd_n     (ft_rd_n),
        .ft_wr_n     (ft_wr_n),
        .ft_addr     (ft_addr),
        .ft_wdata    (ft_wdata),
        .ft_rdata    (ft_rdata),
        .lout_data   (lout_data),
        .lout_srdy   (lout_srdy),
        .lout_drdy   (lout_drdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // FIB RAM with one-cycle read latency, plus bus monitors
    logic [53:0] mem [16];
    int          both_low;
    int          watch_wr;
    logic [3:0]  watch_addr;

    always @(posedge clk) begin
        if (!ft_wr_n) mem[ft_addr] <= ft_wdata;
        if (!ft_rd_n) ft_rdata <= mem[ft_addr];
        if (!ft_wr_n && !ft_rd_n) both_low++;
        if (!ft_wr_n && ft_addr == watch_addr) watch_wr++;
    end

    // Reference model: MAC table indexed by hash, validity only
    logic        mdl_vld  [16];
    logic [47:0] mdl_mac  [16];
    logic [1:0]  mdl_port [16];

    function automatic logic [3:0] hf(input logic [47:0] m);
        logic [3:0] h = '0;
        for (int i = 0; i < 12; i++) h = h ^ m[4*i +: 4];
        return h;
    endfunction

    function automatic logic [3:0] flood_of(input logic [1:0] src);
        logic [3:0] one = 4'b0001;
        return ~(one << src);
    endfunction

    function automatic logic [3:0] mdl_mask(input logic [47:0] da, input logic [1:0] src);
        logic [3:0] h   = hf(da);
        logic [3:0] one = 4'b0001;
        if (da[40]) return flood_of(src);
        if (mdl_vld[h] && mdl_mac[h] == da) return (mdl_port[h] == src) ? 4'b0000 : (one << mdl_port[h]);
        return flood_of(src);
    endfunction

    task automatic mdl_learn(input logic [47:0] sa, input logic [1:0] src);
        logic [3:0] h = hf(sa);
        mdl_vld[h]  = 1'b1;
        mdl_mac[h]  = sa;
        mdl_port[h] = src;
    endtask

    task automatic mdl_clear();
        for (int i = 0; i < 16; i++) mdl_vld[i] = 1'b0;
    endtask

    // Presents one descriptor, holding off lout_drdy for 'hold' cycles of valid mask.
    task automatic send_pkt(input logic [47:0] da, input logic [47:0] sa, input logic [1:0] src,
                            input int hold, output logic [3:0] mask, output int lat,
                            output bit stable, output int rd_held, output bit tmo);
        int t    = 0;
        int held = 0;
        bit got  = 0;
        mask = 'x; lat = -1; stable = 1; rd_held = 0; tmo = 1;
        lpp_macda = da; lpp_macsa = sa; lpp_srcport = src; lpp_srdy = 1'b1;
        while (t < 300) begin
            lout_drdy = (held >= hold);
            #1;
            if (lout_srdy) begin
                if (!got) begin
                    got  = 1;
                    mask = lout_data;
                end else if (lout_data !== mask) begin
                    stable = 0;
                end
                if (!lout_drdy) begin
                    held++;
                    if (!ft_rd_n) rd_held++;
                end
            end
            if (lpp_drdy) begin
                lat = t;
                tmo = 0;
                break;
            end
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        lpp_srdy  = 1'b0;
        lout_drdy = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; lpp_srdy = 1'b1; lpp_macda = 48'h5; lpp_macsa = 48'h7;
        lpp_srcport = 2'd1; lout_drdy = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({lpp_drdy, lout_srdy, lout_data, ft_rd_n, ft_wr_n, ft_addr, ft_wdata} !== {1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 4'h0, 54'h0}) begin
            errs++;
            $display("FAIL reset_outputs: drdy=%b srdy=%b data=%h rd_n=%b wr_n=%b addr=%h wdata=%h, want 0 0 0 1 1 0 0",
                     lpp_drdy, lout_srdy, lout_data, ft_rd_n, ft_wr_n, ft_addr, ft_wdata);
        end
        lpp_srdy = 1'b0; lout_drdy = 1'b0;
    endtask

    task automatic test_init();
        @(negedge clk);
        reset = 1'b0;
        mdl_clear();
        #1;
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (ft_wr_n !== 1'b0 || ft_rd_n !== 1'b1 || ft_addr !== 4'(i) || ft_wdata !== 54'h0) begin
                errs++;
                $display("FAIL init_write[%0d]: wr_n=%b rd_n=%b addr=%0d wdata=%h, want 0 1 %0d 0",
                         i, ft_wr_n, ft_rd_n, ft_addr, ft_wdata, i);
            end
            @(negedge clk);
            #1;
        end
        checks++;
        if (ft_wr_n !== 1'b1) begin
            errs++;
            $display("FAIL init_done: wr_n=%b after 16 writes, want 1", ft_wr_n);
        end
    endtask

    task automatic test_unicast_unknown();
        logic [3:0] m; int lat; bit st; int rh; bit tmo;
        logic [47:0] sa = 48'h0000_0000_00A7;
        send_pkt(48'h0000_0000_0005, sa, 2'd2, 0, m, lat, st, rh, tmo);
        mdl_learn(sa, 2'd2);
        checks++;
        if (tmo || m !== 4'b1011) begin
            errs++;
            $display("FAIL unicast_unknown_mask: got %b (timeout=%0d), want 1011", m, tmo);
        end
        checks++;
        if (lat < 3 || lat > 5) begin
            errs++;
            $display("FAIL unicast_latency: got %0d cycles, want 3..5", lat);
        end
        checks++;
        if (mem[hf(sa)] !== {4'd3, 2'd2, sa}) begin
            errs++;
            $display("FAIL sa_learn_entry: got %h, want %h", mem[hf(sa)], {4'd3, 2'd2, sa});
        end
    endtask

    task automatic test_learned();
        logic [3:0] m; int lat; bit st; int rh; bit tmo;
        logic [47:0] mac = 48'h0000_0000_0012;
        send_pkt(48'h0000_0000_0100, mac, 2'd1, 0, m, lat, st, rh, tmo);
        mdl_learn(mac, 2'd1);
        send_pkt(mac, 48'h0000_0000_0007, 2'd3, 0, m, lat, st, rh, tmo);
        mdl_learn(48'h0000_0000_0007, 2'd3);
        checks++;
        if (tmo || m !== 4'b0010) begin
            errs++;
            $display("FAIL known_da_mask: got %b (timeout=%0d), want 0010", m, tmo);
        end
        send_pkt(48'h0000_0000_0100, mac, 2'd3, 0, m, lat, st, rh, tmo);
        mdl_learn(mac, 2'd3);
        send_pkt(mac, 48'h0000_0000_0009, 2'd3, 0, m, lat, st, rh, tmo);
        mdl_learn(48'h0000_0000_0009, 2'd3);
        checks++;
        if (tmo || m !== 4'b0000) begin
            errs++;
            $display("FAIL same_port_filter: got %b (timeout=%0d), want 0000", m, tmo);
        end
    endtask

    task automatic test_multicast_hold();
        logic [3:0] m; int lat; bit st; int rh; bit tmo;
        send_pkt(48'h0100_5E00_0001, 48'h0000_0000_00B0, 2'd0, 5, m, lat, st, rh, tmo);
        mdl_learn(48'h0000_0000_00B0, 2'd0);
        checks++;
        if (tmo || m !== 4'b1110) begin
            errs++;
            $display("FAIL mcast_mask: got %b (timeout=%0d), want 1110", m, tmo);
        end
        checks++;
        if (!st) begin
            errs++;
            $display("FAIL mcast_stable: mask changed while lout_drdy low, want stable");
        end
        checks++;
        if (rh != 0) begin
            errs++;
            $display("FAIL mcast_no_read: %0d FIB reads while mask pending, want 0", rh);
        end
        checks++;
        if (lat < 7 || lat > 9) begin
            errs++;
            $display("FAIL mcast_latency: got %0d cycles with 5 held, want 7..9", lat);
        end
    endtask

    task automatic test_aging();
        logic [3:0] m; int lat; bit st; int rh; bit tmo;
        logic [47:0] mac = 48'h0000_0000_0C30;
        send_pkt(48'h0000_0000_0100, mac, 2'd1, 0, m, lat, st, rh, tmo);
        checks++;
        if (mem[4'hF][53:50] !== 4'd3) begin
            errs++;
            $display("FAIL age_after_learn: got %0d, want 3", mem[4'hF][53:50]);
        end
        repeat (4*16*64) @(negedge clk);
        mdl_clear();
        checks++;
        if (mem[4'hF][53:50] !== 4'd0) begin
            errs++;
            $display("FAIL age_expired: got %0d, want 0", mem[4'hF][53:50]);
        end
        send_pkt(mac, 48'h0000_0000_0007, 2'd0, 0, m, lat, st, rh, tmo);
        mdl_learn(48'h0000_0000_0007, 2'd0);
        checks++;
        if (tmo || m !== 4'b1110) begin
            errs++;
            $display("FAIL aged_lookup_floods: got %b (timeout=%0d), want 1110", m, tmo);
        end
        send_pkt(48'h0000_0000_0100, mac, 2'd1, 0, m, lat, st, rh, tmo);
        mdl_learn(mac, 2'd1);
        checks++;
        if (mem[4'hF] !== {4'd3, 2'd1, mac}) begin
            errs++;
            $display("FAIL relearn_entry: got %h, want %h", mem[4'hF], {4'd3, 2'd1, mac});
        end
        watch_addr = 4'hF;
        watch_wr   = 0;
        send_pkt(48'h0000_0000_0100, mac, 2'd1, 0, m, lat, st, rh, tmo);
        checks++;
        if (tmo || watch_wr != 0) begin
            errs++;
            $display("FAIL fresh_relearn_no_write: %0d writes (timeout=%0d), want 0", watch_wr, tmo);
        end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        bit done = 0;
        logic [3:0] m = 'x;
        lpp_macda = 48'h0000_0000_0012; lpp_macsa = 48'h0000_0000_00C1;
        lpp_srcport = 2'd0; lout_drdy = 1'b0; lpp_srdy = 1'b1;
        #1;
        while (!lout_srdy && n < 50) begin
            @(negedge clk); #1; n++;
        end
        checks++;
        if (!lout_srdy) begin
            errs++;
            $display("FAIL reach_da_res: lout_srdy=%b after %0d cycles, want 1", lout_srdy, n);
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({lpp_drdy, lout_srdy, lout_data, ft_rd_n, ft_wr_n, ft_addr, ft_wdata} !== {1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 4'h0, 54'h0}) begin
            errs++;
            $display("FAIL mid_reset_outputs: drdy=%b srdy=%b data=%h rd_n=%b wr_n=%b addr=%h, want 0 0 0 1 1 0",
                     lpp_drdy, lout_srdy, lout_data, ft_rd_n, ft_wr_n, ft_addr);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        mdl_clear();
        #1;
        checks++;
        if (ft_wr_n !== 1'b0 || ft_addr !== 4'h0) begin
            errs++;
            $display("FAIL init_rerun: wr_n=%b addr=%0d, want 0 0", ft_wr_n, ft_addr);
        end
        lout_drdy = 1'b1;
        n = 0;
        while (!done && n < 200) begin
            if (lout_srdy) m = lout_data;
            if (lpp_drdy) done = 1;
            else begin
                @(negedge clk); #1; n++;
            end
        end
        @(negedge clk);
        lpp_srdy = 1'b0; lout_drdy = 1'b0;
        mdl_learn(48'h0000_0000_00C1, 2'd0);
        checks++;
        if (!done || m !== 4'b1110) begin
            errs++;
            $display("FAIL repacket_after_reset: mask=%b done=%0d, want 1110 1", m, done);
        end
    endtask

    task automatic test_random();
        logic [47:0] pool [6];
        logic [3:0] m; logic [3:0] exp; int lat; bit st; int rh; bit tmo;
        logic [47:0] da; logic [47:0] sa; logic [1:0] src; int hold; int r;
        for (int i = 0; i < 6; i++) begin
            pool[i] = {16'($urandom), 32'($urandom)};
            pool[i][40] = 1'b0;
        end
        for (int k = 0; k < 40; k++) begin
            r = int'($urandom_range(0, 9));
            if (r < 6) da = pool[r];
            else da = {16'($urandom), 32'($urandom)};
            if (r == 6 || r == 7) da[40] = 1'b0;
            if (r >= 8) da[40] = 1'b1;
            sa   = pool[$urandom_range(0, 5)];
            src  = 2'($urandom_range(0, 3));
            hold = int'($urandom_range(0, 2));
            exp  = mdl_mask(da, src);
            send_pkt(da, sa, src, hold, m, lat, st, rh, tmo);
            mdl_learn(sa, src);
            checks++;
            if (tmo || m !== exp) begin
                errs++;
                $display("FAIL random_mask[%0d]: da=%h src=%0d got %b (timeout=%0d), want %b", k, da, src, m, tmo, exp);
            end
            checks++;
            if (!st) begin
                errs++;
                $display("FAIL random_stable[%0d]: mask changed during hold=%0d, want stable", k, hold);
            end
        end
    endtask

    initial begin
        errs = 0; checks = 0; both_low = 0; watch_wr = 0; watch_addr = 4'h0;
        lpp_macda = '0; lpp_macsa = '0; lpp_srcport = '0; lpp_srdy = 1'b0; lout_drdy = 1'b0;
        reset = 1'b1;
        test_reset();
        test_init();
        test_unicast_unknown();
        test_learned();
        test_multicast_hold();
        test_aging();
        test_reset_mid();
        test_random();
        checks++;
        if (both_low != 0) begin
            errs++;
            $display("FAIL rd_wr_exclusive: %0d cycles with both strobes low, want 0", both_low);
        end
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
